// File: rtl/alu_seq_if.sv
// Handshaked operand/result bundle for alu_seq: one request channel, one result channel.
// in_valid/in_ready and out_valid/out_ready follow valid/ready rules. A beat moves on a rising edge where
// both signals are high. A producer holds valid and its payload until the beat moves.
interface alu_seq_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, alu_result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_op, in_a, in_b, out_ready,
    output in_ready, out_valid, alu_result, zero, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops register their result one cycle after accept.
// MUL iterates shift-add over XLEN cycles.
module alu_seq #(
  parameter int XLEN       = 64,
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus,
  output logic [0:0] state_dbg
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [CW-1:0] CNT_FULL = CW'(XLEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            zero_q, zero_d;
  logic            ill_q, ill_d;
  logic            out_valid_q, out_valid_d;

  logic            in_ready;
  logic            accept;
  logic            is_mul;
  logic [XLEN-1:0] op_res;
  logic            op_ill;
  logic [XLEN-1:0] acc_step;
  logic            slt_bit;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign is_mul   = (MUL_ENABLE != 1'b0) && (bus.alu_op == OP_MUL);
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign slt_bit  = $signed(bus.in_a) < $signed(bus.in_b);

  // Op 1000 lands in the default arm. That arm flags it illegal unless is_mul redirects it to the multiplier.
  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
    case (bus.alu_op)
      OP_AND:  op_res = bus.in_a & bus.in_b;
      OP_OR:   op_res = bus.in_a | bus.in_b;
      OP_XOR:  op_res = bus.in_a ^ bus.in_b;
      OP_ADD:  op_res = bus.in_a + bus.in_b;
      OP_SUB:  op_res = bus.in_a - bus.in_b;
      OP_SLL:  op_res = bus.in_a << bus.in_b[SW-1:0];
      OP_SRL:  op_res = bus.in_a >> bus.in_b[SW-1:0];
      OP_SLT:  op_res = {{(XLEN-1){1'b0}}, slt_bit};
      default: op_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    res_d       = res_q;
    zero_d      = zero_q;
    ill_d       = ill_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mcand_d     = bus.in_a;
            mplier_d    = bus.in_b;
            acc_d       = '0;
            cnt_d       = CNT_FULL;
            out_valid_d = 1'b0;
            state_d     = S_MUL;
          end else begin
            res_d       = op_res;
            zero_d      = (op_res == '0);
            ill_d       = op_ill;
            out_valid_d = 1'b1;
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_ONE;
        // The last step publishes the accumulator including this edge's partial product.
        if (cnt_q == CNT_ONE) begin
          res_d       = acc_step;
          zero_d      = (acc_step == '0);
          ill_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      zero_q      <= 1'b1;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      ill_q       <= ill_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_result = res_q;
  assign bus.zero       = zero_q;
  assign bus.illegal    = ill_q;
  assign state_dbg      = state_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with three instances: 64-bit with MUL, 64-bit without MUL, and 32-bit.
// Expected values are hand-computed constants.
module tb_alu_seq;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [63:0] exp_q[$];
  logic [0:0]  state_dbg0, state_dbg1, state_dbg2;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

  alu_seq_if #(.XLEN(64)) if0 ();
  alu_seq_if #(.XLEN(64)) if1 ();
  alu_seq_if #(.XLEN(32)) if2 ();

  alu_seq #(.XLEN(64), .MUL_ENABLE(1'b1)) u0 (.clk(clk), .reset(reset), .bus(if0), .state_dbg(state_dbg0));
  alu_seq #(.XLEN(64), .MUL_ENABLE(1'b0)) u1 (.clk(clk), .reset(reset), .bus(if1), .state_dbg(state_dbg1));
  alu_seq #(.XLEN(32), .MUL_ENABLE(1'b1)) u2 (.clk(clk), .reset(reset), .bus(if2), .state_dbg(state_dbg2));

  // Streaming vectors: XOR, SLL 1<<63, SRL, SLT -1<0, SLT 0<-1, shift by 0, shift by 64, SLT min<max.
  logic [3:0]  s_op [8] = '{4'b0011, 4'b0100, 4'b0101, 4'b0111, 4'b0111, 4'b0100, 4'b0101, 4'b0111};
  logic [63:0] s_a  [8] = '{64'hF0F0, 64'd1, MSB, ONES, 64'd0, 64'h1234, 64'h1234, MSB};
  logic [63:0] s_b  [8] = '{64'hFF00, 64'd63, 64'd63, 64'd0, ONES, 64'd0, 64'd64, 64'h7FFF_FFFF_FFFF_FFFF};
  logic [63:0] s_e  [8] = '{64'h0FF0, MSB, 64'd1, 64'd1, 64'd0, 64'h1234, 64'h1234, 64'd1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one single-cycle op on u0 and check its result once out_valid rises.
  task automatic op0(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input logic exp_ill, input string tag);
    int guard;
    guard = 0;
    while (!if0.in_ready && guard < 100) begin
      tick();
      guard++;
    end
    chk({tag, " in_ready"}, 64'(if0.in_ready), 64'd1);
    if0.in_valid = 1'b1;
    if0.alu_op   = op;
    if0.in_a     = a;
    if0.in_b     = b;
    tick();
    if0.in_valid = 1'b0;
    if0.in_a     = {$urandom, $urandom};
    if0.in_b     = {$urandom, $urandom};
    guard = 0;
    while (!if0.out_valid && guard < 200) begin
      tick();
      guard++;
    end
    chk({tag, " out_valid"}, 64'(if0.out_valid), 64'd1);
    chk({tag, " result"}, if0.alu_result, exp);
    chk({tag, " zero"}, 64'(if0.zero), 64'(exp == 64'd0));
    chk({tag, " illegal"}, 64'(if0.illegal), 64'(exp_ill));
  endtask

  // Issue a MUL on u0; check latency, in_ready low while busy, and the product.
  task automatic mul0(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp, input string tag);
    int cyc;
    logic saw_ready;
    chk({tag, " in_ready"}, 64'(if0.in_ready), 64'd1);
    if0.in_valid = 1'b1;
    if0.alu_op   = 4'b1000;
    if0.in_a     = a;
    if0.in_b     = b;
    tick();
    if0.in_valid = 1'b0;
    if0.in_a     = {$urandom, $urandom};
    if0.in_b     = {$urandom, $urandom};
    cyc       = 0;
    saw_ready = 1'b0;
    while (!if0.out_valid && cyc < 200) begin
      saw_ready = saw_ready | if0.in_ready;
      tick();
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'd64);
    chk({tag, " busy in_ready"}, 64'(saw_ready), 64'd0);
    chk({tag, " result"}, if0.alu_result, exp);
    chk({tag, " zero"}, 64'(if0.zero), 64'(exp == 64'd0));
  endtask

  // Same op on u1 (64-bit, no MUL) and/or u2 (32-bit); each has its own expectation.
  task automatic aux_op(input bit en1, input bit en2, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp1, input logic ill1,
                        input logic [63:0] exp2, input logic ill2, input string tag);
    if1.in_valid = en1;
    if2.in_valid = en2;
    if1.alu_op   = op;
    if2.alu_op   = op;
    if1.in_a     = a;
    if1.in_b     = b;
    if2.in_a     = a[31:0];
    if2.in_b     = b[31:0];
    tick();
    if1.in_valid = 1'b0;
    if2.in_valid = 1'b0;
    if (en1) begin
      chk({tag, " x64 out_valid"}, 64'(if1.out_valid), 64'd1);
      chk({tag, " x64 result"}, if1.alu_result, exp1);
      chk({tag, " x64 zero"}, 64'(if1.zero), 64'(exp1 == 64'd0));
      chk({tag, " x64 illegal"}, 64'(if1.illegal), 64'(ill1));
    end
    if (en2) begin
      chk({tag, " x32 out_valid"}, 64'(if2.out_valid), 64'd1);
      chk({tag, " x32 result"}, 64'(if2.alu_result), exp2);
      chk({tag, " x32 zero"}, 64'(if2.zero), 64'(exp2 == 64'd0));
      chk({tag, " x32 illegal"}, 64'(if2.illegal), 64'(ill2));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    if0.in_valid = 1'b0; if0.alu_op = 4'd0; if0.in_a = '0; if0.in_b = '0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.alu_op = 4'd0; if1.in_a = '0; if1.in_b = '0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.alu_op = 4'd0; if2.in_a = '0; if2.in_b = '0; if2.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // Reset state.
    chk("rst out_valid", 64'(if0.out_valid), 64'd0);
    chk("rst in_ready", 64'(if0.in_ready), 64'd1);
    chk("rst result", if0.alu_result, 64'd0);
    chk("rst zero", 64'(if0.zero), 64'd1);
    chk("rst illegal", 64'(if0.illegal), 64'd0);
    chk("rst state", 64'(state_dbg0), 64'd0);
    chk("rst x32 zero", 64'(if2.zero), 64'd1);

    // Reset in the middle of a MUL aborts it with no result.
    if0.in_valid = 1'b1; if0.alu_op = 4'b1000; if0.in_a = 64'd5; if0.in_b = 64'd7;
    tick();
    if0.in_valid = 1'b0;
    repeat (4) tick();
    chk("mid-mul state", 64'(state_dbg0), 64'd1);
    chk("mid-mul in_ready", 64'(if0.in_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("abort out_valid", 64'(if0.out_valid), 64'd0);
    chk("abort in_ready", 64'(if0.in_ready), 64'd1);
    chk("abort zero", 64'(if0.zero), 64'd1);
    tick();
    reset = 1'b0;
    repeat (70) tick();
    chk("abort no result", 64'(if0.out_valid), 64'd0);
    op0(4'b0010, 64'd3, 64'd4, 64'd7, 1'b0, "add after abort");

    // Single-cycle ops on u0, issued back to back.
    op0(4'b0000, 64'd3, 64'd4, 64'd0, 1'b0, "and 3,4");
    op0(4'b0010, 64'd3, 64'd3, 64'd6, 1'b0, "add 3,3");
    op0(4'b0110, 64'd5, 64'd5, 64'd0, 1'b0, "sub 5,5");
    op0(4'b0001, 64'd3, 64'd4, 64'd7, 1'b0, "or 3,4");
    op0(4'b1111, 64'd3, 64'd4, 64'd0, 1'b1, "op 1111");
    op0(4'b1001, 64'd9, 64'd9, 64'd0, 1'b1, "op 1001");
    op0(4'b0011, 64'd6, 64'd5, 64'd3, 1'b0, "xor clears illegal");

    // Wrap cases on the 64-bit instance.
    op0(4'b0010, ONES, 64'd1, 64'd0, 1'b0, "add wrap");
    op0(4'b0110, 64'd0, 64'd1, ONES, 1'b0, "sub wrap");
    tick();

    // Iterative multiplies.
    mul0(64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0001, ONES, "mul big");
    tick();
    mul0(64'd0, 64'h1234, 64'd0, "mul zero");
    tick();
    mul0(ONES, ONES, 64'd1, "mul -1*-1");
    op0(4'b0010, 64'd10, 64'd20, 64'd30, 1'b0, "add after mul");
    tick();
    mul0(64'd12345, 64'd678, 64'd8369910, "mul 12345*678");
    tick();

    // Backpressure: the result holds while out_ready is low, then moves once.
    if0.out_ready = 1'b0;
    op0(4'b0010, 64'd1, 64'd1, 64'd2, 1'b0, "bp add 1,1");
    if0.in_valid = 1'b1; if0.alu_op = 4'b0010; if0.in_a = 64'd9; if0.in_b = 64'd9;
    for (int i = 0; i < 5; i++) begin
      chk("bp in_ready", 64'(if0.in_ready), 64'd0);
      tick();
      chk("bp out_valid", 64'(if0.out_valid), 64'd1);
      chk("bp held result", if0.alu_result, 64'd2);
    end
    if0.in_valid  = 1'b0;
    if0.out_ready = 1'b1;
    tick();
    chk("bp single transfer", 64'(if0.out_valid), 64'd0);
    chk("bp result kept", if0.alu_result, 64'd2);

    // Streaming: a new op every cycle, results in order.
    for (int i = 0; i < 8; i++) begin
      if0.in_valid = 1'b1;
      if0.alu_op   = s_op[i];
      if0.in_a     = s_a[i];
      if0.in_b     = s_b[i];
      exp_q.push_back(s_e[i]);
      chk("stream in_ready", 64'(if0.in_ready), 64'd1);
      tick();
      chk("stream out_valid", 64'(if0.out_valid), 64'd1);
      chk("stream result", if0.alu_result, exp_q.pop_front());
    end
    if0.in_valid = 1'b0;
    tick();
    chk("stream drained", 64'(if0.out_valid), 64'd0);

    // No-MUL 64-bit instance and the 32-bit instance.
    aux_op(1'b1, 1'b0, 4'b1000, 64'd3, 64'd4, 64'd0, 1'b1, 64'd0, 1'b0, "op 1000 no mul");
    aux_op(1'b1, 1'b0, 4'b0010, 64'd3, 64'd3, 64'd6, 1'b0, 64'd0, 1'b0, "add clears illegal");
    aux_op(1'b1, 1'b1, 4'b0010, 64'h0000_0000_FFFF_FFFF, 64'd1,
           64'h0000_0001_0000_0000, 1'b0, 64'd0, 1'b0, "add wrap32");
    aux_op(1'b1, 1'b1, 4'b0110, 64'd0, 64'd1, ONES, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, "sub wrap32");
    aux_op(1'b1, 1'b1, 4'b0100, 64'd1, 64'd31, 64'h8000_0000, 1'b0, 64'h8000_0000, 1'b0, "sll 31");
    aux_op(1'b1, 1'b1, 4'b0100, 64'd1, 64'd32, 64'h1_0000_0000, 1'b0, 64'd1, 1'b0, "sll 32");
    aux_op(1'b1, 1'b1, 4'b0111, 64'h8000_0000, 64'd1, 64'd0, 1'b0, 64'd1, 1'b0, "slt sign32");
    aux_op(1'b1, 1'b1, 4'b0110, 64'd7, 64'd7, 64'd0, 1'b0, 64'd0, 1'b0, "sub equal");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
